// File: rtl/wb_regfile_if.sv
// Writeback/read-port bundle between the MEM/WB stage, decode and the register file.
// The pipeline side drives writes and read addresses; the register file returns read data.
interface wb_regfile_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 5
);
   logic                    regwren;
   logic [0:ADDR_W-1]       rwraddrd;
   logic                    reginmuxop;
   logic [0:DATA_W/8-1]     wbyteen;
   logic [0:DATA_W-1]       dataOut;
   logic [0:DATA_W-1]       aluOut;
   logic [0:ADDR_W-1]       raddra;
   logic [0:ADDR_W-1]       raddrb;
   logic [0:DATA_W-1]       rdataa;
   logic [0:DATA_W-1]       rdatab;
   logic [0:DATA_W-1]       wbdata;

   modport master (
      output regwren, rwraddrd, reginmuxop, wbyteen, dataOut, aluOut, raddra, raddrb,
      input  rdataa, rdatab, wbdata
   );

   modport slave (
      input  regwren, rwraddrd, reginmuxop, wbyteen, dataOut, aluOut, raddra, raddrb,
      output rdataa, rdatab, wbdata
   );
endinterface

// File: rtl/wb_regfile.sv
// Writeback mux plus a 32 x 128-bit byte-masked register file with two combinational
// read ports that see a same-cycle write through a per-byte bypass merge.
module wb_regfile #(
   parameter int DATA_W   = 128,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input logic          clk,
   input logic          reset,
   wb_regfile_if.slave  bus
);
   localparam int NBYTES = DATA_W / 8;

   logic [0:DATA_W-1] regs [NUM_REGS];
   logic [0:DATA_W-1] wb_value;
   logic [0:DATA_W-1] read_a;
   logic [0:DATA_W-1] read_b;
   logic              bypass_a;
   logic              bypass_b;

   assign wb_value   = bus.reginmuxop ? bus.dataOut : bus.aluOut;
   assign bus.wbdata = wb_value;

   // Lanes are big-endian: lane i occupies bits [8i : 8i+7] of the word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
      end else if (bus.regwren) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (bus.wbyteen[i]) begin
               regs[bus.rwraddrd][8*i +: 8] <= wb_value[8*i +: 8];
            end
         end
      end
   end

   assign bypass_a = bus.regwren && !reset && (bus.raddra == bus.rwraddrd);
   assign bypass_b = bus.regwren && !reset && (bus.raddrb == bus.rwraddrd);

   // Each port merges the in-flight write byte by byte over the stored word.
   always_comb begin
      read_a = regs[bus.raddra];
      read_b = regs[bus.raddrb];
      for (int i = 0; i < NBYTES; i++) begin
         if (bypass_a && bus.wbyteen[i]) begin
            read_a[8*i +: 8] = wb_value[8*i +: 8];
         end
         if (bypass_b && bus.wbyteen[i]) begin
            read_b[8*i +: 8] = wb_value[8*i +: 8];
         end
      end
   end

   assign bus.rdataa = read_a;
   assign bus.rdatab = read_b;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a table of write/read vectors with hand-computed
// results, then hand-written reset sequences around the storage array.
module tb_wb_regfile;
   localparam logic [0:127] PAT  = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [0:127] AAS  = {16{8'hAA}};
   localparam logic [0:127] FIVES = {16{8'h55}};
   localparam logic [0:127] ONES = {16{8'h11}};
   localparam logic [0:127] M3   = {8'h55, {14{8'hAA}}, 8'h55};
   localparam logic [0:127] M4   = {{8{8'h00}}, {8{8'h11}}};
   localparam logic [0:127] Z    = '0;

   typedef struct {
      logic         regwren;
      logic [0:4]   rwraddrd;
      logic         reginmuxop;
      logic [0:15]  wbyteen;
      logic [0:127] data_out;
      logic [0:127] alu_out;
      logic [0:4]   raddra;
      logic [0:4]   raddrb;
      logic [0:127] exp_a;
      logic [0:127] exp_b;
      logic [0:127] exp_wb;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   vec_t vecs[16];

   wb_regfile_if #(.DATA_W(128), .ADDR_W(5)) bus ();

   wb_regfile dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [0:127] act, input logic [0:127] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      bus.regwren    = v.regwren;
      bus.rwraddrd   = v.rwraddrd;
      bus.reginmuxop = v.reginmuxop;
      bus.wbyteen    = v.wbyteen;
      bus.dataOut    = v.data_out;
      bus.aluOut     = v.alu_out;
      bus.raddra     = v.raddra;
      bus.raddrb     = v.raddrb;
      #1;
   endtask

   task automatic idleBus();
      bus.regwren    = 1'b0;
      bus.rwraddrd   = '0;
      bus.reginmuxop = 1'b0;
      bus.wbyteen    = '0;
      bus.dataOut    = '0;
      bus.aluOut     = '0;
      bus.raddra     = '0;
      bus.raddrb     = '0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      logic [7:0] fill_byte;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      idleBus();

      // Each vector is driven mid-low-phase and its write commits on the next rising edge.
      vecs[0]  = '{1'b0, 5'd0,  1'b0, 16'hFFFF, Z,     Z,     5'd0,  5'd17, Z,     Z,     Z};
      vecs[1]  = '{1'b0, 5'd0,  1'b0, 16'h0000, Z,     Z,     5'd17, 5'd31, Z,     Z,     Z};
      vecs[2]  = '{1'b1, 5'd5,  1'b0, 16'hFFFF, Z,     PAT,   5'd5,  5'd0,  PAT,   Z,     PAT};
      vecs[3]  = '{1'b0, 5'd0,  1'b0, 16'h0000, Z,     Z,     5'd5,  5'd5,  PAT,   PAT,   Z};
      vecs[4]  = '{1'b1, 5'd5,  1'b1, 16'hFFFF, AAS,   PAT,   5'd1,  5'd2,  Z,     Z,     AAS};
      vecs[5]  = '{1'b1, 5'd5,  1'b1, 16'h8001, FIVES, Z,     5'd5,  5'd4,  M3,    Z,     FIVES};
      vecs[6]  = '{1'b0, 5'd0,  1'b0, 16'h0000, Z,     Z,     5'd5,  5'd5,  M3,    M3,    Z};
      vecs[7]  = '{1'b1, 5'd9,  1'b0, 16'h00FF, Z,     ONES,  5'd9,  5'd9,  M4,    M4,    ONES};
      vecs[8]  = '{1'b0, 5'd0,  1'b0, 16'h0000, Z,     Z,     5'd9,  5'd9,  M4,    M4,    Z};
      vecs[9]  = '{1'b1, 5'd3,  1'b0, 16'hFFFF, Z,     PAT,   5'd0,  5'd0,  Z,     Z,     PAT};
      vecs[10] = '{1'b0, 5'd3,  1'b0, 16'hFFFF, Z,     AAS,   5'd3,  5'd3,  PAT,   PAT,   AAS};
      vecs[11] = '{1'b1, 5'd3,  1'b0, 16'h0000, Z,     AAS,   5'd3,  5'd3,  PAT,   PAT,   AAS};
      vecs[12] = '{1'b0, 5'd0,  1'b1, 16'h0000, FIVES, Z,     5'd3,  5'd0,  PAT,   Z,     FIVES};
      vecs[13] = '{1'b1, 5'd0,  1'b1, 16'hFFFF, FIVES, Z,     5'd0,  5'd3,  FIVES, PAT,   FIVES};
      vecs[14] = '{1'b0, 5'd0,  1'b0, 16'h0000, Z,     Z,     5'd0,  5'd5,  FIVES, M3,    Z};
      vecs[15] = '{1'b1, 5'd17, 1'b0, 16'hFFFF, Z,     PAT,   5'd17, 5'd18, PAT,   Z,     PAT};

      // Reads while reset is held, with a write attempt that must be ignored.
      @(negedge clk);
      bus.regwren = 1'b1;
      bus.rwraddrd = 5'd17;
      bus.wbyteen = 16'hFFFF;
      bus.aluOut = PAT;
      bus.raddra = 5'd17;
      bus.raddrb = 5'd31;
      #1;
      checkOutput("reset_hold_rdataa", bus.rdataa, Z);
      checkOutput("reset_hold_rdatab", bus.rdatab, Z);
      checkOutput("reset_hold_wbdata", bus.wbdata, PAT);
      @(negedge clk);
      idleBus();
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d_rdataa", i), bus.rdataa, vecs[i].exp_a);
         checkOutput($sformatf("v%0d_rdatab", i), bus.rdatab, vecs[i].exp_b);
         checkOutput($sformatf("v%0d_wbdata", i), bus.wbdata, vecs[i].exp_wb);
      end

      // Fill every register with a distinct nonzero pattern and read them back.
      for (int r = 0; r < 32; r++) begin
         @(negedge clk);
         fill_byte      = 8'(r + 1);
         bus.regwren    = 1'b1;
         bus.rwraddrd   = 5'(r);
         bus.reginmuxop = 1'b0;
         bus.wbyteen    = 16'hFFFF;
         bus.aluOut     = {16{fill_byte}};
      end
      @(negedge clk);
      idleBus();
      for (int r = 0; r < 32; r += 5) begin
         fill_byte  = 8'(r + 1);
         bus.raddra = 5'(r);
         bus.raddrb = 5'(31 - r);
         #1;
         checkOutput($sformatf("fill_rdataa_r%0d", r), bus.rdataa, {16{fill_byte}});
         fill_byte = 8'(32 - r);
         checkOutput($sformatf("fill_rdatab_r%0d", 31 - r), bus.rdatab, {16{fill_byte}});
      end

      // Reset asserted mid-cycle while a write to reg 7 is pending.
      @(negedge clk);
      bus.regwren  = 1'b1;
      bus.rwraddrd = 5'd7;
      bus.wbyteen  = 16'hFFFF;
      bus.aluOut   = PAT;
      bus.raddra   = 5'd7;
      bus.raddrb   = 5'd31;
      #1;
      checkOutput("pre_reset_bypass_r7", bus.rdataa, PAT);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_r7", bus.rdataa, Z);
      checkOutput("async_reset_r31", bus.rdatab, Z);
      checkOutput("async_reset_wbdata", bus.wbdata, PAT);
      @(posedge clk);
      #1;
      checkOutput("reset_edge_r7", bus.rdataa, Z);

      // Release with the write still presented; it must land on the next edge.
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("release_bypass_r7", bus.rdataa, PAT);
      @(negedge clk);
      bus.regwren = 1'b0;
      bus.raddrb  = 5'd8;
      #1;
      checkOutput("post_release_r7", bus.rdataa, PAT);
      checkOutput("post_release_r8", bus.rdatab, Z);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
